bloom_counter_rmw: RTL and testbench
====================================

// Module: bloom_counter_rmw
// PURPOSE
//  Read-modify-write client for the SRAM arbiter's port-1 pair (rd_1_*/wr_1_*), directly upstream of the arbiter.
//  Maintains a counting Bloom filter: each 36-bit SRAM word holds nine 4-bit counters, slot s = bits [4s+3:4s].
//  Accepts INC/DEC/READ/CLEAR commands through a 4-deep FIFO and keeps at most one SRAM access outstanding.
//  No read-after-write hazard is possible.
// PARAMETERS
//  SRAM_ADDR_WIDTH  19  SRAM word address width
//  SRAM_DATA_WIDTH  36  SRAM word width (nine 4-bit counters)
//  RD_TIMEOUT       8   cycles to wait for rd_vld after rd_ack before aborting
// PORTS
//  clk         in   1   system clock; single clock domain
//  reset_n     in   1   asynchronous active-low reset
//  cmd_valid   in   1   command present
//  cmd_ready   out  1   FIFO not full; command accepted when cmd_valid && cmd_ready
//  cmd_op      in   2   00 INC, 01 DEC, 10 READ, 11 CLEAR (zero the whole word)
//  cmd_addr    in   SRAM_ADDR_WIDTH  word address
//  cmd_slot    in   4   counter slot, legal 0..8
//  rsp_vld     out  1   one-cycle pulse: command retired
//  rsp_count   out  4   counter value before modification (0 for CLEAR/error)
//  rsp_err     out  1   qualifies rsp_vld: illegal slot or read timeout
//  rd_req      out  1   read request pulse to arbiter
//  rd_addr     out  SRAM_ADDR_WIDTH
//  rd_ack      in   1   arbiter grant, one cycle after the granted request
//  rd_vld      in   1   read data valid
//  rd_data     in   SRAM_DATA_WIDTH
//  wr_req      out  1   write request pulse to arbiter
//  wr_addr     out  SRAM_ADDR_WIDTH
//  wr_data     out  SRAM_DATA_WIDTH
//  wr_ack      in   1   arbiter grant
// BEHAVIOUR
//  Reset (async): FIFO empty, FSM=IDLE; all outputs 0 except cmd_ready=1.
//  FIFO: 4 entries {op,addr,slot}. Push on valid&&ready; a simultaneous push and pop is allowed when full.
//  Requests are single-cycle pulses (the arbiter samples level every cycle; a held request is double-granted).
//   - Cycle after a pulse: ack=1 means granted; ack=0 means re-pulse next cycle (lost to a higher-priority port).
//   - Addr/data held stable from the pulse until ack is seen.
//  FSM:
//   IDLE -> pop FIFO head when non-empty.
//    slot>8 -> ERR. CLEAR -> WR_REQ with data 0. Else -> RD_REQ.
//   RD_REQ: rd_req=1 for 1 cycle -> RD_ACK.
//   RD_ACK: rd_ack ? RD_DATA (timer cleared) : RD_REQ.
//   RD_DATA: on rd_vld latch word; old = word[4s+3:4s].
//    INC: new=min(old+1,15). DEC: new=max(old-1,0). Only slot s changes; other 32 bits preserved.
//    READ, or INC at 15, or DEC at 0 -> DONE (no write issued). Else -> WR_REQ.
//    Timer reaches RD_TIMEOUT without rd_vld -> ERR.
//   WR_REQ: wr_req=1 for 1 cycle -> WR_ACK.
//   WR_ACK: wr_ack ? DONE : WR_REQ.
//   DONE: rsp_vld=1, rsp_err=0, rsp_count=old -> IDLE.
//   ERR: rsp_vld=1, rsp_err=1, rsp_count=0 -> IDLE.
//  Nominal latency from pop, uncontended: read+write 9 cycles (1 pulse, 1 ack, 4 to rd_vld, then write), READ 7.
//  rd_vld arriving outside RD_DATA is ignored.
//  Reset mid-operation: request abandoned and FIFO flushed; a late rd_vld/ack is ignored in IDLE.
// TESTING
//  1. Word 0x000000000, INC addr 5 slot 0 -> rd_req@5, wr_data=0x000000001, rsp_count=0.
//  2. Slot 8 = 0xF, INC -> no wr_req, rsp_count=15, rsp_err=0; DEC on 0 -> no write, rsp_count=0.
//  3. Hold rd_ack low for 3 pulses -> rd_req re-pulsed each alternate cycle; exactly one grant, one rsp.
//  4. cmd_slot=9 -> no SRAM traffic, rsp_vld with rsp_err=1; next command proceeds normally.
//  5. Push 5 back-to-back -> cmd_ready drops after 4; all 5 retire in order with correct rsp_count.
//  6. Suppress rd_vld -> rsp_err after RD_TIMEOUT cycles; CLEAR then writes 0 without a prior rd_req.

Source files
------------

// File: rtl/bloom_counter_rmw_if.sv
// Interfaces for bloom_counter_rmw: the command/response channel and the
// SRAM arbiter read/write port pair.
interface bloom_cmd_if #(
    parameter int ADDR_W = 19
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [3:0]        cmd_slot;
    logic              rsp_vld;
    logic [3:0]        rsp_count;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_slot,
        input  cmd_ready, rsp_vld, rsp_count, rsp_err
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_slot,
        output cmd_ready, rsp_vld, rsp_count, rsp_err
    );
endinterface

interface sram_port_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 36
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_vld;
    logic [DATA_W-1:0] rd_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_ack, rd_vld, rd_data, wr_ack
    );
    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_ack, rd_vld, rd_data, wr_ack
    );
endinterface

// File: rtl/bloom_counter_rmw.sv
// Counting-Bloom-filter read-modify-write client: nine 4-bit counters per SRAM
// word, commands queued in a 4-deep FIFO, one SRAM access outstanding at a time.
module bloom_counter_rmw #(
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 36,
    parameter int RD_TIMEOUT      = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    bloom_cmd_if.slave  cmd,
    sram_port_if.master sram
);
    localparam int TMR_W = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [1:0] {OP_INC, OP_DEC, OP_READ, OP_CLEAR} op_e;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_ACK, S_RD_DATA, S_WR_REQ, S_WR_ACK, S_DONE, S_ERR
    } state_e;

    typedef struct packed {
        op_e                        op;
        logic [SRAM_ADDR_WIDTH-1:0] addr;
        logic [3:0]                 slot;
    } entry_t;

    state_e                     state_q, state_d;
    op_e                        op_q, op_d;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]                 slot_q, slot_d;
    logic [SRAM_DATA_WIDTH-1:0] word_q, word_d;
    logic [3:0]                 old_q, old_d;
    logic [TMR_W-1:0]           timer_q, timer_d;

    entry_t     fifo_mem_q [4];
    entry_t     push_entry, head;
    logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       push, pop, full, empty;

    assign full  = (count_q == 3'd4);
    assign empty = (count_q == 3'd0);
    assign pop   = (state_q == S_IDLE) && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign cmd.cmd_ready = !full || pop;
    assign push  = cmd.cmd_valid && cmd.cmd_ready;
    assign head  = fifo_mem_q[rd_ptr_q];

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        push_entry = '{op: op_e'(cmd.cmd_op), addr: cmd.cmd_addr, slot: cmd.cmd_slot};
        wr_ptr_d   = wr_ptr_q + {1'b0, push};
        rd_ptr_d   = rd_ptr_q + {1'b0, pop};
        count_d    = count_q + {2'b00, push} - {2'b00, pop};
    end

    // NOTE: FIFO storage has no reset; only the pointers and count need one.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= push_entry;
    end

    logic [5:0] slot_lsb;
    logic [3:0] old_cnt, new_cnt;
    logic       rd_req, wr_req, rsp_vld, rsp_err;
    logic [3:0] rsp_count;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        slot_d    = slot_q;
        word_d    = word_q;
        old_d     = old_q;
        timer_d   = timer_q;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        rsp_vld   = 1'b0;
        rsp_err   = 1'b0;
        rsp_count = 4'd0;

        slot_lsb = (slot_q > 4'd8) ? 6'd0 : {slot_q, 2'b00};
        old_cnt  = sram.rd_data[slot_lsb +: 4];
        new_cnt  = old_cnt;
        if (op_q == OP_INC && old_cnt != 4'hF) new_cnt = old_cnt + 4'd1;
        if (op_q == OP_DEC && old_cnt != 4'h0) new_cnt = old_cnt - 4'd1;

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    op_d   = head.op;
                    addr_d = head.addr;
                    slot_d = head.slot;
                    word_d = '0;
                    old_d  = 4'd0;
                    if (head.slot > 4'd8)         state_d = S_ERR;
                    else if (head.op == OP_CLEAR) state_d = S_WR_REQ;
                    else                          state_d = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                rd_req  = 1'b1;
                state_d = S_RD_ACK;
            end
            S_RD_ACK: begin
                if (sram.rd_ack) begin
                    state_d = S_RD_DATA;
                    timer_d = '0;
                end else begin
                    state_d = S_RD_REQ;
                end
            end
            S_RD_DATA: begin
                if (sram.rd_vld) begin
                    old_d                  = old_cnt;
                    word_d                 = sram.rd_data;
                    word_d[slot_lsb +: 4]  = new_cnt;
                    // READ and saturated INC/DEC leave the counter unchanged: skip the write.
                    state_d = (new_cnt == old_cnt) ? S_DONE : S_WR_REQ;
                end else if (timer_q == TMR_W'(RD_TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WR_REQ: begin
                wr_req  = 1'b1;
                state_d = S_WR_ACK;
            end
            S_WR_ACK: begin
                state_d = sram.wr_ack ? S_DONE : S_WR_REQ;
            end
            S_DONE: begin
                rsp_vld   = 1'b1;
                rsp_count = old_q;
                state_d   = S_IDLE;
            end
            S_ERR: begin
                rsp_vld = 1'b1;
                rsp_err = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_INC;
            addr_q   <= '0;
            slot_q   <= '0;
            word_q   <= '0;
            old_q    <= '0;
            timer_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            slot_q   <= slot_d;
            word_q   <= word_d;
            old_q    <= old_d;
            timer_q  <= timer_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign sram.rd_req    = rd_req;
    assign sram.rd_addr   = addr_q;
    assign sram.wr_req    = wr_req;
    assign sram.wr_addr   = addr_q;
    assign sram.wr_data   = word_q;
    assign cmd.rsp_vld    = rsp_vld;
    assign cmd.rsp_err    = rsp_err;
    assign cmd.rsp_count  = rsp_count;
endmodule

// File: tb/tb_bloom_counter_rmw.sv
// Scoreboard bench for bloom_counter_rmw: a word-level counter model predicts each
// response at issue time; an arbiter/SRAM model answers the DUT's requests.
module tb_bloom_counter_rmw;
    localparam int AW    = 19;
    localparam int DW    = 36;
    localparam int MEM_N = 64;
    localparam bit [1:0] OP_INC = 2'd0, OP_DEC = 2'd1, OP_READ = 2'd2, OP_CLEAR = 2'd3;

    typedef struct {
        bit       err;
        bit [3:0] count;
    } exp_t;

    logic clk;
    logic reset_n;

    bloom_cmd_if #(.ADDR_W(AW)) cmd_if ();
    sram_port_if #(.ADDR_W(AW), .DATA_W(DW)) sram_if ();

    bloom_counter_rmw #(
        .SRAM_ADDR_WIDTH(AW),
        .SRAM_DATA_WIDTH(DW),
        .RD_TIMEOUT(8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .cmd    (cmd_if),
        .sram   (sram_if)
    );

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];

    bit [DW-1:0] model_mem [MEM_N];
    bit [DW-1:0] snap_mem  [MEM_N];
    bit [DW-1:0] sram_mem  [MEM_N];

    // Arbiter model controls (written by the main sequence only).
    int deny_rd_target = 0;
    int spurious_req   = 0;
    bit suppress_vld   = 0;
    bit rand_deny      = 0;

    // Arbiter model state and statistics (written by the arbiter process only).
    int rd_pulses = 0, rd_grants = 0, wr_pulses = 0, wr_grants = 0;
    int denied_rd = 0, held_viol = 0, spurious_done = 0;
    int vld_wait = 0, vld_addr = 0;
    bit rd_pend = 0, wr_pend = 0, prev_rd = 0, prev_wr = 0;
    logic [AW-1:0] rd_pa, wr_pa, last_rd_addr;
    logic [DW-1:0] wr_pd, last_wr_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_push(input bit [1:0] op, input int addr, input int slot);
        exp_t e;
        longint unsigned w;
        longint unsigned unit;
        int old;
        e.err   = 1'b0;
        e.count = 4'd0;
        w = 64'(model_mem[addr]);
        if (slot > 8 || (suppress_vld && op != OP_CLEAR)) begin
            e.err = 1'b1;
        end else if (op == OP_CLEAR) begin
            model_mem[addr] = '0;
        end else begin
            unit    = 64'd1 << (4 * slot);
            old     = int'((w >> (4 * slot)) & 64'hF);
            e.count = 4'(old);
            if (op == OP_INC && old < 15) w = w + unit;
            if (op == OP_DEC && old > 0)  w = w - unit;
            model_mem[addr] = DW'(w);
        end
        exp_q.push_back(e);
    endtask

    task automatic send_cmd(input bit [1:0] op, input int addr, input int slot);
        int n = 0;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_addr  = AW'(addr);
        cmd_if.cmd_slot  = 4'(slot);
        while (!cmd_if.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_if.cmd_ready) check("cmd_ready_wait", 64'(cmd_if.cmd_ready), 64'd1);
        else                   model_push(op, addr, slot);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending_rsp", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
    endtask

    // Arbiter + SRAM model: grants arrive the cycle after a request pulse,
    // read data 1..5 cycles after the grant.
    initial begin
        sram_if.rd_ack  = 1'b0;
        sram_if.rd_vld  = 1'b0;
        sram_if.rd_data = '0;
        sram_if.wr_ack  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            sram_if.rd_ack  = 1'b0;
            sram_if.wr_ack  = 1'b0;
            sram_if.rd_vld  = 1'b0;
            sram_if.rd_data = DW'({$urandom, $urandom});
            if (vld_wait > 0) begin
                vld_wait--;
                if (vld_wait == 0) begin
                    sram_if.rd_vld  = 1'b1;
                    sram_if.rd_data = sram_mem[vld_addr];
                end
            end else if (spurious_done != spurious_req) begin
                spurious_done++;
                sram_if.rd_vld  = 1'b1;
                sram_if.rd_data = '1;
            end
            if (rd_pend) begin
                if (denied_rd < deny_rd_target || (rand_deny && $urandom_range(0, 3) == 0)) begin
                    denied_rd++;
                end else begin
                    sram_if.rd_ack = 1'b1;
                    rd_grants++;
                    if (!suppress_vld) begin
                        vld_wait = int'($urandom_range(1, 5));
                        vld_addr = int'(rd_pa[5:0]);
                    end
                end
            end
            if (wr_pend && !(rand_deny && $urandom_range(0, 3) == 0)) begin
                sram_if.wr_ack = 1'b1;
                wr_grants++;
                sram_mem[int'(wr_pa[5:0])] = wr_pd;
            end
            #1;
            rd_pend = sram_if.rd_req;
            wr_pend = sram_if.wr_req;
            rd_pa   = sram_if.rd_addr;
            wr_pa   = sram_if.wr_addr;
            wr_pd   = sram_if.wr_data;
            if (rd_pend) begin
                rd_pulses++;
                last_rd_addr = rd_pa;
                if (prev_rd) held_viol++;
            end
            if (wr_pend) begin
                wr_pulses++;
                last_wr_data = wr_pd;
                if (prev_wr) held_viol++;
            end
            prev_rd = rd_pend;
            prev_wr = wr_pend;
        end
    end

    // Response monitor: pops the scoreboard whenever the DUT retires a command.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && cmd_if.rsp_vld) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got rsp_vld=1 count=%0d err=%0d, expected no response",
                             cmd_if.rsp_count, cmd_if.rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_err", 64'(cmd_if.rsp_err), 64'(e.err));
                    check("rsp_count", 64'(cmd_if.rsp_count), 64'(e.count));
                end
            end
        end
    end

    initial begin
        int base_rd, base_wr, base_gr;
        bit [1:0] op;
        int r, slot;

        reset_n          = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = '0;
        cmd_if.cmd_addr  = '0;
        cmd_if.cmd_slot  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", 64'(cmd_if.cmd_ready), 64'd1);
        check("reset_rsp_vld",   64'(cmd_if.rsp_vld),   64'd0);
        check("reset_rsp_count", 64'(cmd_if.rsp_count), 64'd0);
        check("reset_rd_req",    64'(sram_if.rd_req),   64'd0);
        check("reset_wr_req",    64'(sram_if.wr_req),   64'd0);
        check("reset_rd_addr",   64'(sram_if.rd_addr),  64'd0);
        check("reset_wr_data",   64'(sram_if.wr_data),  64'd0);
        reset_n = 1'b1;

        // INC on an all-zero word writes back exactly 1 in slot 0.
        base_wr = wr_pulses;
        send_cmd(OP_INC, 5, 0);
        drain();
        check("t1_rd_addr", 64'(last_rd_addr), 64'd5);
        check("t1_wr_data", 64'(last_wr_data), 64'h1);
        check("t1_wr_count", 64'(wr_pulses - base_wr), 64'd1);

        // Saturation: fill slot 8 of word 6, then INC at 15 and DEC at 0 write nothing.
        for (int i = 0; i < 15; i++) send_cmd(OP_INC, 6, 8);
        drain();
        base_wr = wr_pulses;
        send_cmd(OP_INC, 6, 8);
        send_cmd(OP_DEC, 6, 0);
        drain();
        check("t2_no_write", 64'(wr_pulses - base_wr), 64'd0);
        check("t2_word6", 64'(sram_mem[6]), 64'hF_0000_0000);

        // Three lost grants: four read pulses, one grant, one response.
        base_rd = rd_pulses;
        base_gr = rd_grants;
        deny_rd_target = denied_rd + 3;
        send_cmd(OP_READ, 5, 0);
        drain();
        check("t3_rd_pulses", 64'(rd_pulses - base_rd), 64'd4);
        check("t3_rd_grants", 64'(rd_grants - base_gr), 64'd1);

        // Illegal slot: error response with no SRAM traffic, then normal service.
        base_rd = rd_pulses;
        base_wr = wr_pulses;
        send_cmd(OP_INC, 7, 9);
        drain();
        check("t4_no_rd", 64'(rd_pulses - base_rd), 64'd0);
        check("t4_no_wr", 64'(wr_pulses - base_wr), 64'd0);
        send_cmd(OP_INC, 7, 3);
        drain();
        check("t4_word7", 64'(sram_mem[7]), 64'h1000);

        // Five back-to-back commands: the fifth fills the FIFO behind a busy FSM.
        for (int i = 0; i < 5; i++) send_cmd(OP_INC, 10 + i, i);
        check("t5_ready_full", 64'(cmd_if.cmd_ready), 64'd0);
        drain();

        // Read timeout, a stray rd_vld while idle, then CLEAR with no read.
        suppress_vld = 1'b1;
        send_cmd(OP_INC, 5, 0);
        drain();
        suppress_vld = 1'b0;
        spurious_req++;
        repeat (12) @(posedge clk);
        base_rd = rd_pulses;
        base_wr = wr_pulses;
        send_cmd(OP_CLEAR, 5, 2);
        drain();
        check("t6_clear_no_rd", 64'(rd_pulses - base_rd), 64'd0);
        check("t6_clear_wr", 64'(wr_pulses - base_wr), 64'd1);
        check("t6_word5", 64'(sram_mem[5]), 64'd0);

        // Reset mid-operation flushes the FIFO; a late grant/data is ignored.
        snap_mem = model_mem;
        send_cmd(OP_INC, 20, 1);
        send_cmd(OP_READ, 21, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        model_mem = snap_mem;
        @(negedge clk);
        check("rst_mid_ready", 64'(cmd_if.cmd_ready), 64'd1);
        check("rst_mid_rd_req", 64'(sram_if.rd_req), 64'd0);
        reset_n = 1'b1;
        base_rd = rd_pulses;
        repeat (20) @(posedge clk);
        check("rst_mid_flushed", 64'(rd_pulses - base_rd), 64'd0);

        // Randomized traffic with contended grants on both ports.
        rand_deny = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r  = int'($urandom_range(0, 9));
            op = (r < 5) ? OP_INC : (r < 8) ? OP_DEC : (r == 8) ? OP_READ : OP_CLEAR;
            slot = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
            send_cmd(op, int'($urandom_range(0, 31)), slot);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();
        rand_deny = 1'b0;

        for (int a = 0; a < 32; a++) check($sformatf("mem_word_%0d", a), 64'(sram_mem[a]), 64'(model_mem[a]));
        check("held_request_pulses", 64'(held_viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
